// File: rtl/sym_fir_pkg.sv
// Shared constants, default types and reset-coefficient helper for the symmetric FIR.
package sym_fir_pkg;
  localparam int LATENCY   = 4;
  localparam int DEF_WIDTH = 18;

  typedef logic signed [DEF_WIDTH-1:0] sample_t;
  typedef logic signed [DEF_WIDTH-1:0] coef_t;

  // Unity-gain impulse: only the centre tap is non-zero (max positive 1sX).
  function automatic longint impulse_coef(input int width, input int idx, input int num_coef);
    return (idx == num_coef-1) ? ((longint'(1) << (width-1)) - 1) : 64'sd0;
  endfunction
endpackage

// File: rtl/sym_fir_coef_bank.sv
// Shadow/active coefficient banks with a strobe-aligned swap (IDLE/PENDING) and busy flag.
module sym_fir_coef_bank
  import sym_fir_pkg::*;
#(
  parameter int WIDTH    = 18,
  parameter int NUM_COEF = 11,
  parameter int ADDR_W   = $clog2(NUM_COEF)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sam_clk_en,
  input  logic                             coef_wr,
  input  logic [ADDR_W-1:0]                coef_addr,
  input  logic [WIDTH-1:0]                 coef_data,
  input  logic                             coef_swap,
  output logic                             coef_busy,
  output logic [NUM_COEF-1:0][WIDTH-1:0]   active
);
  typedef enum logic {IDLE, PENDING} state_t;

  state_t                           state;
  logic [NUM_COEF-1:0][WIDTH-1:0]   shadow, shadow_nxt;

  // Out-of-range addresses never match, so they are silently dropped.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NUM_COEF; i++)
      if (coef_wr && coef_addr == ADDR_W'(i)) shadow_nxt[i] = coef_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      coef_busy <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow[i] <= WIDTH'(impulse_coef(WIDTH, i, NUM_COEF));
        active[i] <= WIDTH'(impulse_coef(WIDTH, i, NUM_COEF));
      end
    end else begin
      shadow <= shadow_nxt;
      case (state)
        IDLE:
          if (coef_swap) begin
            state     <= PENDING;
            coef_busy <= 1'b1;
          end
        PENDING:
          // Copy from shadow_nxt so a write landing on the swap edge is included.
          if (sam_clk_en) begin
            active    <= shadow_nxt;
            state     <= IDLE;
            coef_busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sym_fir_filt.sv
// Pipelined linear-phase FIR: delay line -> fold -> multiply -> sum/round into y.
// Define SYM_FIR_SAT_EN to saturate the output instead of wrapping.
module sym_fir_filt
  import sym_fir_pkg::*;
#(
  parameter int WIDTH    = 18,
  parameter int NUM_TAPS = 21,
  parameter int NUM_COEF = (NUM_TAPS+1)/2,
  parameter int ADDR_W   = $clog2(NUM_COEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sam_clk_en,
  input  logic [WIDTH-1:0]  x_in,
  input  logic              coef_wr,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [WIDTH-1:0]  coef_data,
  input  logic              coef_swap,
  output logic              coef_busy,
  output logic [WIDTH-1:0]  y,
  output logic              y_valid
);
  localparam int STAGES = LATENCY-1;
  localparam int PW     = 2*WIDTH+1;
  localparam int SW     = PW + $clog2(NUM_COEF);
  localparam int CTR    = NUM_COEF-1;
  localparam logic [SW-1:0] RND = SW'(1) << (WIDTH-2);

  logic [NUM_COEF-1:0][WIDTH-1:0] coef;
  logic [NUM_TAPS-1:0][WIDTH-1:0] dl;
  logic signed [WIDTH:0]          pre  [NUM_COEF];
  logic signed [PW-1:0]           prod [NUM_COEF];
  logic signed [SW-1:0]           acc, rnd;
  logic [WIDTH-1:0]               res;
  logic [STAGES:0]                vld_pipe;
  logic                           unused_ok;

  sym_fir_coef_bank #(.WIDTH(WIDTH), .NUM_COEF(NUM_COEF), .ADDR_W(ADDR_W)) u_bank (
    .clk        (clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .coef_wr    (coef_wr),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_swap  (coef_swap),
    .coef_busy  (coef_busy),
    .active     (coef)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl       <= '0;
      vld_pipe <= '0;
      for (int k = 0; k < NUM_COEF; k++) begin
        pre[k]  <= '0;
        prod[k] <= '0;
      end
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], sam_clk_en};
      if (sam_clk_en) dl <= {dl[NUM_TAPS-2:0], x_in};
      for (int k = 0; k < CTR; k++)
        pre[k] <= {dl[k][WIDTH-1], dl[k]} + {dl[NUM_TAPS-1-k][WIDTH-1], dl[NUM_TAPS-1-k]};
      pre[CTR] <= {dl[CTR][WIDTH-1], dl[CTR]};
      for (int k = 0; k < NUM_COEF; k++)
        prod[k] <= PW'(pre[k]) * PW'($signed(coef[k]));
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_COEF; k++) acc = acc + SW'(prod[k]);
    rnd = acc + RND;
  end

`ifdef SYM_FIR_SAT_EN
  logic [SW-2*WIDTH+1:0] hi;
  assign hi = rnd[SW-1:2*WIDTH-2];

  // Guard bits must all equal the result sign bit, otherwise clamp.
  always_comb begin
    res = rnd[WIDTH-1 +: WIDTH];
    if (!(&hi) && (|hi))
      res = rnd[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign res = rnd[WIDTH-1 +: WIDTH];
`endif

  assign unused_ok = ^{rnd[WIDTH-2:0], rnd[SW-1:2*WIDTH-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    y <= '0;
    else if (vld_pipe[STAGES-1])  y <= res;
  end

  assign y_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_sym_fir_filt.sv
// Self-checking bench for sym_fir_filt: direct-form reference model plus directed vectors.
module tb_sym_fir_filt;
  import sym_fir_pkg::*;

  localparam int W   = 18;
  localparam int NT  = 21;
  localparam int NC  = 11;
  localparam int AW  = 4;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;

  logic            clk = 1'b0, reset = 1'b1;
  logic            sam_clk_en = 1'b0, coef_wr = 1'b0, coef_swap = 1'b0;
  sample_t         x_in = '0;
  coef_t           coef_data = '0;
  logic [AW-1:0]   coef_addr = '0;
  logic            coef_busy, y_valid;
  logic [W-1:0]    y;

  sym_fir_filt #(.WIDTH(W), .NUM_TAPS(NT)) dut (
    .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .x_in(x_in),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_swap(coef_swap), .coef_busy(coef_busy), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed { int due; int idx; } job_t;
  typedef struct packed { int due; int val; } out_t;

  int   cyc = 0, n_cmp = 0, n_err = 0;
  int   hist[$];
  int   m_shadow[NC], m_active[NC];
  bit   m_busy = 1'b0;
  job_t mq[$];
  out_t outq[$];
  int   last_y = 0;
  int   got[$];
  int   vcount = 0, run = 0, max_run = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Direct-form convolution over the sample history: h[t] = c[min(t, NT-1-t)].
  function automatic int model_y(input int idx);
    longint s = 0, r;
    for (int t = 0; t < NT; t++) begin
      int c;
      c = (t < NT-1-t) ? t : NT-1-t;
      if (idx - t >= 0) s += longint'(hist[idx-t]) * longint'(m_active[c]);
    end
    r = (s + (64'sd1 <<< (W-2))) >>> (W-1);
`ifdef SYM_FIR_SAT_EN
    if (r > MAXV) r = MAXV;
    if (r < -MAXV-1) r = -MAXV-1;
`else
    r = r & ((64'sd1 <<< W) - 1);
    if (r > MAXV) r = r - (64'sd1 <<< W);
`endif
    return int'(r);
  endfunction

  // Reference model: samples shifted on edge c are multiplied on edge c+2
  // with whatever coefficient set is active just before that edge.
  always @(posedge clk) begin
    job_t j;
    cyc++;
    if (reset) begin
      hist.delete(); mq.delete(); outq.delete();
      m_busy = 1'b0;
      for (int i = 0; i < NC; i++) begin
        m_shadow[i] = (i == NC-1) ? int'(MAXV) : 0;
        m_active[i] = m_shadow[i];
      end
    end else begin
      while (mq.size() > 0 && mq[0].due == cyc) begin
        j = mq.pop_front();
        outq.push_back('{due: cyc+1, val: model_y(j.idx)});
      end
      if (coef_wr && int'(coef_addr) < NC) m_shadow[coef_addr] = int'($signed(coef_data));
      if (m_busy && sam_clk_en) begin
        m_active = m_shadow;
        m_busy = 1'b0;
      end else if (coef_swap && !m_busy) m_busy = 1'b1;
      if (sam_clk_en) begin
        hist.push_back(int'($signed(x_in)));
        mq.push_back('{due: cyc+2, idx: hist.size()-1});
      end
    end
  end

  always @(negedge clk) begin
    bit   ev;
    out_t o;
    if (!reset) begin
      while (outq.size() > 0 && outq[0].due < cyc) o = outq.pop_front();
      ev = (outq.size() > 0 && outq[0].due == cyc);
      chk("y_valid", int'(y_valid), int'(ev));
      if (ev) begin
        o = outq.pop_front();
        chk("y", int'($signed(y)), o.val);
        last_y = o.val;
      end else chk("y_hold", int'($signed(y)), last_y);
      chk("coef_busy", int'(coef_busy), int'(m_busy));
      if (y_valid) begin
        got.push_back(int'($signed(y)));
        vcount++;
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
    end else begin
      last_y = 0;
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic strobe(input int x);
    sam_clk_en = 1'b1; x_in = W'(x); tick(); sam_clk_en = 1'b0;
  endtask
  task automatic strobe4(input int x);
    strobe(x); idle(3);
  endtask
  task automatic wr(input int a, input int d);
    coef_wr = 1'b1; coef_addr = AW'(a); coef_data = W'(d); tick(); coef_wr = 1'b0;
  endtask
  task automatic swap();
    coef_swap = 1'b1; tick(); coef_swap = 1'b0;
  endtask
  task automatic impulse_check(input string tag);
    int nz;
    got.delete();
    strobe4(1000);
    for (int i = 0; i < 14; i++) strobe4(0);
    idle(6);
    nz = 0;
    for (int i = 0; i < got.size(); i++) if (i != 10 && got[i] != 0) nz++;
    chk({tag, "_count"}, got.size(), 15);
    chk({tag, "_tap10"}, (got.size() > 10) ? got[10] : -1, 1000);
    chk({tag, "_others_zero"}, nz, 0);
  endtask

  initial begin
    int v0;
    idle(2);
    chk("rst_y", int'($signed(y)), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_busy", int'(coef_busy), 0);
    reset = 1'b0;
    tick();

    impulse_check("impulse");

    // Single strobe: y_valid only on the 4th edge after it.
    strobe(5000);
    chk("lat_e0", int'(y_valid), 0); tick();
    chk("lat_e1", int'(y_valid), 0); tick();
    chk("lat_e2", int'(y_valid), 0); tick();
    chk("lat_e3", int'(y_valid), 1); tick();
    chk("lat_e4", int'(y_valid), 0);
    idle(4);

    v0 = vcount; max_run = 0;
    for (int i = 0; i < 30; i++) begin
      sam_clk_en = 1'b1; x_in = W'(i*8737 - 131072); tick();
    end
    sam_clk_en = 1'b0;
    idle(6);
    chk("b2b_count", vcount - v0, 30);
    chk("b2b_run", max_run, 30);

    // Flat 2^12 coefficients: DC gain 21*4096/2^17.
    for (int a = 0; a < NC; a++) wr(a, 4096);
    chk("load_busy_idle", int'(coef_busy), 0);
    swap();
    chk("swap_busy", int'(coef_busy), 1);
    idle(3);
    chk("swap_wait", int'(coef_busy), 1);
    got.delete();
    strobe(8192);
    chk("swap_clear", int'(coef_busy), 0);
    idle(3);
    for (int i = 0; i < 24; i++) strobe4(8192);
    idle(6);
    chk("dc_gain", got[got.size()-1], 5376);

    // Write on the copy edge is part of the copied set (centre -> 0).
    swap();
    coef_wr = 1'b1; coef_addr = AW'(10); coef_data = '0;
    sam_clk_en = 1'b1; x_in = W'(8192);
    tick();
    coef_wr = 1'b0; sam_clk_en = 1'b0;
    idle(3);
    for (int i = 0; i < 24; i++) strobe4(8192);
    idle(6);
    chk("wr_on_copy", got[got.size()-1], 5120);

    wr(11, 12345);
    swap();
    for (int i = 0; i < 24; i++) strobe4(8192);
    idle(6);
    chk("addr_oob", got[got.size()-1], 5120);

    for (int a = 0; a < NC; a++) wr(a, 131071);
    swap();
    for (int i = 0; i < 30; i++) begin
      sam_clk_en = 1'b1; x_in = W'(131071); tick();
    end
    sam_clk_en = 1'b0;
    idle(6);
`ifdef SYM_FIR_SAT_EN
    chk("full_scale", got[got.size()-1], 131071);
`else
    chk("full_scale", got[got.size()-1], 131030);
`endif

    // Reset with valids in flight and a swap pending.
    for (int i = 0; i < 3; i++) strobe(777);
    swap();
    reset = 1'b1;
    #1;
    chk("midrst_y", int'($signed(y)), 0);
    chk("midrst_y_valid", int'(y_valid), 0);
    chk("midrst_busy", int'(coef_busy), 0);
    idle(2);
    reset = 1'b0;
    tick();
    impulse_check("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
